lfsr_param: RTL and testbench

- Parametrised maximal-length Fibonacci LFSR, the next generation of the fixed-width 16-bit LFSR.
- Adds selectable width, XOR/XNOR feedback, seed load with lock-out protection, and an enable.
- Adds a built-in period checker that counts steps until the state returns to the loaded seed.
- Used as a pseudo-random source and as its own self-test for the final-project datapath.

---
 rtl/lfsr_pkg.sv | 93 +++++++++
 rtl/lfsr_period_chk.sv | 96 +++++++++
 rtl/lfsr_param.sv | 80 ++++++++
 tb/tb_lfsr_param.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised LFSR: maximal tap table, lock-out values
// and the period-checker state encoding.
package lfsr_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } chk_state_t;

    // One-hot mask for a 1-indexed polynomial tap position.
    function automatic logic [63:0] tap(input int t);
        return 64'd1 << (t - 1);
    endfunction

    function automatic logic [63:0] max_taps(input int w);
        logic [63:0] m;
        m = 64'd0;
        case (w)
            3:  m = tap(3)  | tap(2);
            4:  m = tap(4)  | tap(3);
            5:  m = tap(5)  | tap(3);
            6:  m = tap(6)  | tap(5);
            7:  m = tap(7)  | tap(6);
            8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  m = tap(9)  | tap(5);
            10: m = tap(10) | tap(7);
            11: m = tap(11) | tap(9);
            12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: m = tap(15) | tap(14);
            16: m = tap(16) | tap(14) | tap(13) | tap(11);
            17: m = tap(17) | tap(14);
            18: m = tap(18) | tap(11);
            19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: m = tap(20) | tap(17);
            21: m = tap(21) | tap(19);
            22: m = tap(22) | tap(21);
            23: m = tap(23) | tap(18);
            24: m = tap(24) | tap(23) | tap(22) | tap(17);
            25: m = tap(25) | tap(22);
            26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: m = tap(28) | tap(25);
            29: m = tap(29) | tap(27);
            30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: m = tap(31) | tap(28);
            32: m = tap(32) | tap(22) | tap(2)  | tap(1);
            33: m = tap(33) | tap(20);
            34: m = tap(34) | tap(27) | tap(2)  | tap(1);
            35: m = tap(35) | tap(33);
            36: m = tap(36) | tap(25);
            37: m = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
            38: m = tap(38) | tap(6)  | tap(5)  | tap(1);
            39: m = tap(39) | tap(35);
            40: m = tap(40) | tap(38) | tap(21) | tap(19);
            41: m = tap(41) | tap(38);
            42: m = tap(42) | tap(41) | tap(20) | tap(19);
            43: m = tap(43) | tap(42) | tap(38) | tap(37);
            44: m = tap(44) | tap(43) | tap(18) | tap(17);
            45: m = tap(45) | tap(44) | tap(42) | tap(41);
            46: m = tap(46) | tap(45) | tap(26) | tap(25);
            47: m = tap(47) | tap(42);
            48: m = tap(48) | tap(47) | tap(21) | tap(20);
            49: m = tap(49) | tap(40);
            50: m = tap(50) | tap(49) | tap(24) | tap(23);
            51: m = tap(51) | tap(50) | tap(36) | tap(35);
            52: m = tap(52) | tap(49);
            53: m = tap(53) | tap(52) | tap(38) | tap(37);
            54: m = tap(54) | tap(53) | tap(18) | tap(17);
            55: m = tap(55) | tap(31);
            56: m = tap(56) | tap(55) | tap(35) | tap(34);
            57: m = tap(57) | tap(50);
            58: m = tap(58) | tap(39);
            59: m = tap(59) | tap(58) | tap(38) | tap(37);
            60: m = tap(60) | tap(59);
            61: m = tap(61) | tap(60) | tap(46) | tap(45);
            62: m = tap(62) | tap(61) | tap(6)  | tap(5);
            63: m = tap(63) | tap(62);
            64: m = tap(64) | tap(63) | tap(61) | tap(60);
            default: m = 64'd0;
        endcase
        return m;
    endfunction

    // The state a feedback mode can never leave: all-0s for XOR, all-1s for XNOR.
    function automatic logic [63:0] lockout_val(input int w, input bit xnor_mode);
        logic [63:0] ones;
        ones = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return xnor_mode ? ones : 64'd0;
    endfunction

endpackage

// File: rtl/lfsr_period_chk.sv
// Period checker: keeps the reference seed, counts enabled steps and flags either a
// return to the reference or an overrun of 2^WIDTH steps without one.
module lfsr_period_chk
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_REF = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] state_next,
    output logic             period_done,
    output logic [WIDTH:0]   period_count,
    output logic             no_repeat
);
    localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] CNT_FULL = {1'b1, {WIDTH{1'b0}}};

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH:0]   r_cnt;
    logic [WIDTH:0]   w_cnt_inc;
    logic [WIDTH:0]   r_pcount;
    logic             r_done;
    logic             r_norep;
    logic             w_hit_ref;
    logic             w_hit_full;

    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Next-state decode: a repeat takes precedence over the overrun on the same step.
    always_comb begin
        w_state_nxt = r_state;
        w_hit_ref   = 1'b0;
        w_hit_full  = 1'b0;
        case (r_state)
            RUN: begin
                if (step) begin
                    if (state_next == r_ref) begin
                        w_hit_ref   = 1'b1;
                        w_state_nxt = DONE;
                    end else if (w_cnt_inc == CNT_FULL) begin
                        w_hit_full  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = RUN;
        endcase
    end

    // Checker registers; reset beats load, load restarts the measurement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= RUN;
            r_ref    <= RESET_REF;
            r_cnt    <= '0;
            r_pcount <= '0;
            r_done   <= 1'b0;
            r_norep  <= 1'b0;
        end else if (load) begin
            r_state  <= RUN;
            r_ref    <= load_val;
            r_cnt    <= '0;
            r_pcount <= '0;
            r_done   <= 1'b0;
            r_norep  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (step && (r_state == RUN)) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_hit_ref) begin
                r_done   <= 1'b1;
                r_pcount <= w_cnt_inc;
            end
            if (w_hit_full) begin
                r_norep <= 1'b1;
            end
        end
    end

    assign period_done  = r_done;
    assign period_count = r_pcount;
    assign no_repeat    = r_norep;

endmodule

// File: rtl/lfsr_param.sv
// Parametrised maximal-length Fibonacci LFSR with XOR/XNOR feedback, lock-out-safe
// seed loading and a built-in period checker.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter bit          XNOR_MODE    = 1'b0,
    parameter logic [63:0] RESET_SEED   = 64'd1,
    // Non-zero replaces the table polynomial; intended only for exercising the checker.
    parameter logic [63:0] TAP_OVERRIDE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] shift_seed,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH:0]   period_count,
    output logic             no_repeat
);
    localparam logic [63:0]      TAPS_64    = (TAP_OVERRIDE != 64'd0) ? TAP_OVERRIDE : max_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS       = TAPS_64[WIDTH-1:0];
    localparam logic [63:0]      LOCKOUT_64 = lockout_val(WIDTH, XNOR_MODE);
    localparam logic [WIDTH-1:0] LOCKOUT    = LOCKOUT_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SUBST      = XNOR_MODE ? ~ONE : ONE;
    localparam logic [WIDTH-1:0] RST_RAW    = RESET_SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_FIXED  = (RST_RAW == LOCKOUT) ? SUBST : RST_RAW;
    localparam logic             RST_LOCK   = (RST_RAW == LOCKOUT);

    logic [WIDTH-1:0] r_shift;
    logic             r_lockup;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_seed_lock;
    logic [WIDTH-1:0] w_seed_fix;
    logic             w_step;

    assign w_fb        = (^(r_shift & TAPS)) ^ XNOR_MODE;
    assign w_next      = {r_shift[WIDTH-2:0], w_fb};
    assign w_seed_lock = (seed == LOCKOUT);
    assign w_seed_fix  = w_seed_lock ? SUBST : seed;
    assign w_step      = en & ~load;

    // Shift register and lock-out flag; load has priority over stepping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift  <= RST_FIXED;
            r_lockup <= RST_LOCK;
        end else if (load) begin
            r_shift  <= w_seed_fix;
            r_lockup <= w_seed_lock;
        end else if (en) begin
            r_shift  <= w_next;
        end else begin
            r_shift  <= r_shift;
        end
    end

    lfsr_period_chk #(
        .WIDTH     (WIDTH),
        .RESET_REF (RST_FIXED)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .step         (w_step),
        .load         (load),
        .load_val     (w_seed_fix),
        .state_next   (w_next),
        .period_done  (period_done),
        .period_count (period_count),
        .no_repeat    (no_repeat)
    );

    assign shift_seed = r_shift;
    assign lockup     = r_lockup;

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench for lfsr_param: several configurations share one stimulus bus and a
// behavioural model of the selected one predicts every cycle's outputs.
module tb_lfsr_param;

    typedef struct packed {
        logic [63:0] st;
        logic        lk;
        logic        dn;
        logic [64:0] pc;
        logic        nr;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [63:0] seed = 64'd0;

    always #5 clk = ~clk;

    logic [3:0]  s_a, s_o, s_z;
    logic [15:0] s_w;
    logic [7:0]  s_x, s_n;
    logic        l_a, l_w, l_x, l_n, l_o, l_z;
    logic        d_a, d_w, d_x, d_n, d_o, d_z;
    logic        n_a, n_w, n_x, n_n, n_o, n_z;
    logic [4:0]  c_a, c_o, c_z;
    logic [16:0] c_w;
    logic [8:0]  c_x, c_n;

    lfsr_param #(.WIDTH(4)) u_a (.clk(clk), .reset(reset), .en(en), .load(load), .seed(seed[3:0]),
        .shift_seed(s_a), .lockup(l_a), .period_done(d_a), .period_count(c_a), .no_repeat(n_a));
    lfsr_param #(.WIDTH(16)) u_w (.clk(clk), .reset(reset), .en(en), .load(load), .seed(seed[15:0]),
        .shift_seed(s_w), .lockup(l_w), .period_done(d_w), .period_count(c_w), .no_repeat(n_w));
    lfsr_param #(.WIDTH(8), .RESET_SEED(64'd0)) u_x (.clk(clk), .reset(reset), .en(en), .load(load),
        .seed(seed[7:0]), .shift_seed(s_x), .lockup(l_x), .period_done(d_x), .period_count(c_x), .no_repeat(n_x));
    lfsr_param #(.WIDTH(8), .XNOR_MODE(1'b1)) u_n (.clk(clk), .reset(reset), .en(en), .load(load),
        .seed(seed[7:0]), .shift_seed(s_n), .lockup(l_n), .period_done(d_n), .period_count(c_n), .no_repeat(n_n));
    lfsr_param #(.WIDTH(4), .TAP_OVERRIDE(64'hA)) u_o (.clk(clk), .reset(reset), .en(en), .load(load),
        .seed(seed[3:0]), .shift_seed(s_o), .lockup(l_o), .period_done(d_o), .period_count(c_o), .no_repeat(n_o));
    lfsr_param #(.WIDTH(4), .TAP_OVERRIDE(64'h1)) u_z (.clk(clk), .reset(reset), .en(en), .load(load),
        .seed(seed[3:0]), .shift_seed(s_z), .lockup(l_z), .period_done(d_z), .period_count(c_z), .no_repeat(n_z));

    int   sel = 0;
    obs_t obs;

    always_comb begin
        obs = '0;
        case (sel)
            0: begin obs.st = 64'(s_a); obs.lk = l_a; obs.dn = d_a; obs.pc = 65'(c_a); obs.nr = n_a; end
            1: begin obs.st = 64'(s_w); obs.lk = l_w; obs.dn = d_w; obs.pc = 65'(c_w); obs.nr = n_w; end
            2: begin obs.st = 64'(s_x); obs.lk = l_x; obs.dn = d_x; obs.pc = 65'(c_x); obs.nr = n_x; end
            3: begin obs.st = 64'(s_n); obs.lk = l_n; obs.dn = d_n; obs.pc = 65'(c_n); obs.nr = n_n; end
            4: begin obs.st = 64'(s_o); obs.lk = l_o; obs.dn = d_o; obs.pc = 65'(c_o); obs.nr = n_o; end
            5: begin obs.st = 64'(s_z); obs.lk = l_z; obs.dn = d_z; obs.pc = 65'(c_z); obs.nr = n_z; end
            default: obs = '0;
        endcase
    end

    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    obs_t e;

    obs_t        m;
    logic [63:0] m_ref;
    logic [64:0] m_cnt;
    bit          m_fin;
    int          m_w;
    logic [63:0] m_mask;
    bit          m_xn;
    logic [63:0] m_rst;

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic select(input int s);
        sel = s;
        case (s)
            0: begin m_w = 4;  m_mask = 64'hC;    m_xn = 1'b0; m_rst = 64'd1; end
            1: begin m_w = 16; m_mask = 64'hB400; m_xn = 1'b0; m_rst = 64'd1; end
            2: begin m_w = 8;  m_mask = 64'hB8;   m_xn = 1'b0; m_rst = 64'd0; end
            3: begin m_w = 8;  m_mask = 64'hB8;   m_xn = 1'b1; m_rst = 64'd1; end
            4: begin m_w = 4;  m_mask = 64'hA;    m_xn = 1'b0; m_rst = 64'd1; end
            default: begin m_w = 4; m_mask = 64'h1; m_xn = 1'b0; m_rst = 64'd1; end
        endcase
    endtask

    // Drive one cycle of stimulus, advance the model and queue its prediction.
    task automatic cycle(input bit rs, input bit ld, input bit ena, input logic [63:0] sd);
        logic [63:0] lo, v, nx;
        logic [64:0] c;
        reset = ~rs;
        load  = ld;
        en    = ena;
        seed  = sd;
        lo = m_xn ? wmask(m_w) : 64'd0;
        if (rs || ld) begin
            v = (rs ? m_rst : sd) & wmask(m_w);
            m.lk  = (v == lo);
            m.st  = (v == lo) ? (m_xn ? (lo ^ 64'd1) : 64'd1) : v;
            m.dn  = 1'b0;
            m.pc  = 65'd0;
            m.nr  = 1'b0;
            m_ref = m.st;
            m_cnt = 65'd0;
            m_fin = 1'b0;
        end else if (ena) begin
            nx = ((m.st << 1) | 64'((^(m.st & m_mask)) ^ m_xn)) & wmask(m_w);
            if (!m_fin) begin
                c = m_cnt + 65'd1;
                if (nx == m_ref) begin
                    m.dn = 1'b1; m.pc = c; m_fin = 1'b1;
                end else if (c == (65'd1 << m_w)) begin
                    m.nr = 1'b1; m_fin = 1'b1;
                end
                m_cnt = c;
            end
            m.st = nx;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        select(0);
        cycle(1'b1, 1'b0, 1'b0, 64'd0);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_w4: got %h want %h", obs, e); end
        total++;
        if (obs.st !== 64'd1 || obs.dn !== 1'b0 || obs.pc !== 65'd0 || obs.nr !== 1'b0)
            begin bad++; $display("FAIL reset_w4_const: got %h", obs); end
        select(2);
        cycle(1'b1, 1'b0, 1'b0, 64'd0);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_w8_lock: got %h want %h", obs, e); end
        total++;
        if (obs.st !== 64'h01 || obs.lk !== 1'b1)
            begin bad++; $display("FAIL reset_w8_subst: got st=%h lk=%b want 01 1", obs.st, obs.lk); end
    endtask

    task automatic test_seq4;
        logic [3:0] exp_seq [3];
        exp_seq = '{4'h2, 4'h4, 4'h9};
        select(0);
        cycle(1'b0, 1'b1, 1'b0, 64'h1);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL seq4_load: got %h want %h", obs, e); end
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL seq4_step%0d: got %h want %h", i, obs, e); end
            if (i < 3) begin
                total++;
                if (obs.st[3:0] !== exp_seq[i])
                    begin bad++; $display("FAIL seq4_const%0d: got %h want %h", i, obs.st[3:0], exp_seq[i]); end
            end
        end
        total++;
        if (obs.dn !== 1'b1 || obs.pc !== 65'd15 || obs.nr !== 1'b0)
            begin bad++; $display("FAIL seq4_period: got dn=%b pc=%0d nr=%b want 1 15 0", obs.dn, obs.pc, obs.nr); end
    endtask

    task automatic test_enable_hold;
        int n;
        select(0);
        cycle(1'b0, 1'b1, 1'b0, 64'h1);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL hold_load: got %h want %h", obs, e); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, (i < 5), 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL hold_cyc%0d: got %h want %h", i, obs, e); end
        end
        n = 0;
        while (!m_fin && n < 20) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL hold_run%0d: got %h want %h", n, obs, e); end
            n++;
        end
        total++;
        if (obs.dn !== 1'b1 || obs.pc !== 65'd15)
            begin bad++; $display("FAIL hold_period: got dn=%b pc=%0d want 1 15", obs.dn, obs.pc); end
    endtask

    task automatic test_load_priority;
        select(0);
        cycle(1'b0, 1'b1, 1'b0, 64'h1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            void'(exp_q.pop_front());
        end
        cycle(1'b0, 1'b1, 1'b1, 64'h6);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL load_en: got %h want %h", obs, e); end
        total++;
        if (obs.st !== 64'h6) begin bad++; $display("FAIL load_en_const: got %h want 6", obs.st); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL load_run%0d: got %h want %h", i, obs, e); end
        end
        cycle(1'b1, 1'b1, 1'b1, 64'h9);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_wins: got %h want %h", obs, e); end
        total++;
        if (obs.st !== 64'h1 || obs.dn !== 1'b0 || obs.nr !== 1'b0)
            begin bad++; $display("FAIL reset_wins_const: got st=%h dn=%b want 1 0", obs.st, obs.dn); end
    endtask

    task automatic test_lockup;
        logic [63:0] seeds [4];
        int          sels  [4];
        seeds = '{64'h00, 64'h5A, 64'hFF, 64'h00};
        sels  = '{2, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            select(sels[i]);
            cycle(1'b0, 1'b1, 1'b0, seeds[i]);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL lockup%0d: got %h want %h", i, obs, e); end
        end
        total++;
        if (obs.st !== 64'h00 || obs.lk !== 1'b0)
            begin bad++; $display("FAIL lockup_clear: got st=%h lk=%b want 00 0", obs.st, obs.lk); end
    endtask

    task automatic test_nonmax;
        int n;
        select(4);
        cycle(1'b0, 1'b1, 1'b0, 64'h1);
        void'(exp_q.pop_front());
        n = 0;
        while (!m_fin && n < 20) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL nonmax%0d: got %h want %h", n, obs, e); end
            n++;
        end
        total++;
        if (obs.dn !== 1'b1 || obs.pc !== 65'd6 || obs.nr !== 1'b0)
            begin bad++; $display("FAIL nonmax_period: got dn=%b pc=%0d nr=%b want 1 6 0", obs.dn, obs.pc, obs.nr); end
    endtask

    task automatic test_no_repeat;
        select(5);
        cycle(1'b0, 1'b1, 1'b0, 64'h8);
        void'(exp_q.pop_front());
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL norep%0d: got %h want %h", i, obs, e); end
        end
        total++;
        if (obs.nr !== 1'b1 || obs.dn !== 1'b0)
            begin bad++; $display("FAIL norep_flag: got nr=%b dn=%b want 1 0", obs.nr, obs.dn); end
    endtask

    task automatic test_period16;
        int n;
        bit stop;
        select(1);
        cycle(1'b0, 1'b1, 1'b0, 64'hACE1);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL p16_load: got %h want %h", obs, e); end
        n = 0;
        stop = 1'b0;
        while (!m_fin && !stop && n < 65540) begin
            cycle(1'b0, 1'b0, 1'b1, 64'd0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; stop = 1'b1; $display("FAIL p16_step%0d: got %h want %h", n, obs, e); end
            n++;
        end
        total++;
        if (obs.dn !== 1'b1 || obs.pc !== 65'd65535 || obs.nr !== 1'b0)
            begin bad++; $display("FAIL p16_period: got dn=%b pc=%0d nr=%b want 1 65535 0", obs.dn, obs.pc, obs.nr); end
    endtask

    initial begin
        m = '0; m_ref = 64'd0; m_cnt = 65'd0; m_fin = 1'b0;
        select(0);
        #2;
        test_reset();
        test_seq4();
        test_enable_hold();
        test_load_priority();
        test_lockup();
        test_nonmax();
        test_no_repeat();
        test_period16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
